// File: rtl/mips_control_unit_pkg.sv
// Shared MIPS decode definitions: opcodes, control-bit positions and ALUOp classes.
// Imported by the main decoder, ALU-control and the datapath.
package mips_control_unit_pkg;

    localparam int NUM_CTRL = 7;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam int CTRL_REGDST   = 0;
    localparam int CTRL_BRANCH   = 1;
    localparam int CTRL_MEMREAD  = 2;
    localparam int CTRL_MEMTOREG = 3;
    localparam int CTRL_MEMWRITE = 4;
    localparam int CTRL_ALUSRC   = 5;
    localparam int CTRL_REGWRITE = 6;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic [NUM_CTRL-1:0] signals;
        logic [1:0]          aluop;
    } ctrl_t;

    // The no-write bundle used for reset and for every unsupported opcode.
    function automatic ctrl_t ctrl_idle();
        return '0;
    endfunction

endpackage

// File: rtl/mips_control_unit_decode.sv
// Purely combinational opcode-to-control-bundle lookup.
module mips_control_unit_decode
    import mips_control_unit_pkg::*;
(
    input  logic [5:0]          ins,
    output logic [NUM_CTRL-1:0] signals,
    output logic [1:0]          aluop
);

    ctrl_t ctrl;

    always_comb begin
        ctrl = ctrl_idle();
        case (ins)
            OP_RTYPE: begin
                ctrl.signals[CTRL_REGDST]   = 1'b1;
                ctrl.signals[CTRL_REGWRITE] = 1'b1;
                ctrl.aluop                  = ALUOP_FUNCT;
            end
            OP_LW: begin
                ctrl.signals[CTRL_ALUSRC]   = 1'b1;
                ctrl.signals[CTRL_MEMTOREG] = 1'b1;
                ctrl.signals[CTRL_MEMREAD]  = 1'b1;
                ctrl.signals[CTRL_REGWRITE] = 1'b1;
                ctrl.aluop                  = ALUOP_ADD;
            end
            // RegDst/MemtoReg are don't-care for stores; left at 0.
            OP_SW: begin
                ctrl.signals[CTRL_ALUSRC]   = 1'b1;
                ctrl.signals[CTRL_MEMWRITE] = 1'b1;
                ctrl.aluop                  = ALUOP_ADD;
            end
            OP_BEQ: begin
                ctrl.signals[CTRL_BRANCH]   = 1'b1;
                ctrl.aluop                  = ALUOP_SUB;
            end
            default: ctrl = ctrl_idle();
        endcase
    end

    assign signals = ctrl.signals;
    assign aluop   = ctrl.aluop;

endmodule

// File: rtl/mips_control_unit.sv
// Main decoder: registers the decoded control bundle once per cycle,
// with a synchronous reset that forces the no-write bundle.
module mips_control_unit
    import mips_control_unit_pkg::*;
#(
    parameter int NUM_SIGNALS = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [5:0]             ins,
    output logic [NUM_SIGNALS-1:0] signals,
    output logic [1:0]             ALUOp
);

    logic [NUM_CTRL-1:0] dec_signals;
    logic [1:0]          dec_aluop;

    mips_control_unit_decode u_decode (
        .ins     (ins),
        .signals (dec_signals),
        .aluop   (dec_aluop)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            signals <= '0;
            ALUOp   <= ALUOP_ADD;
        end else begin
            signals <= dec_signals;
            ALUOp   <= dec_aluop;
        end
    end

endmodule

// File: tb/tb_mips_control_unit.sv
// Scoreboard bench for mips_control_unit: driver pushes expected bundles,
// monitor pops and compares one cycle later.
module tb_mips_control_unit;

    logic       clk;
    logic       rst;
    logic [5:0] ins;
    logic [6:0] signals;
    logic [1:0] ALUOp;

    int checks = 0;
    int errors = 0;

    bit [8:0] exp_q[$];
    bit [8:0] ref_tbl[bit [5:0]];
    bit [8:0] prev_exp;
    bit       have_prev = 0;

    mips_control_unit #(.NUM_SIGNALS(7)) dut (
        .clk     (clk),
        .rst     (rst),
        .ins     (ins),
        .signals (signals),
        .ALUOp   (ALUOp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: opcode table written straight from the instruction list,
    // entries are {RegWrite,ALUSrc,MemWrite,MemtoReg,MemRead,Branch,RegDst, ALUOp}.
    function automatic bit [8:0] model(input bit r, input bit [5:0] op);
        if (r) return 9'b0;
        if (ref_tbl.exists(op)) return ref_tbl[op];
        return 9'b0;
    endfunction

    task automatic check_hold(input string name);
        checks++;
        if ({signals, ALUOp} !== prev_exp) begin
            errors++;
            $display("FAIL %s: got %b/%b, required %b/%b", name,
                     signals, ALUOp, prev_exp[8:2], prev_exp[1:0]);
        end
    endtask

    // One decode: drive at the falling edge, optionally wiggle ins before the
    // rising edge, then log the expected registered result.
    task automatic step(input bit r, input bit [5:0] op, input bit toggle = 0);
        bit [8:0] e;
        @(negedge clk);
        rst = r;
        ins = (toggle) ? 6'b100011 : op;
        if (toggle) begin
            #1 ins = 6'b101011;
            if (have_prev) check_hold("hold_toggle1");
            #1 ins = 6'b100011;
            if (have_prev) check_hold("hold_toggle2");
            #1 ins = 6'b101011;
            if (have_prev) check_hold("hold_toggle3");
            #1 ins = op;
            if (have_prev) check_hold("hold_toggle4");
        end
        e = model(r, op);
        exp_q.push_back(e);
        prev_exp  = e;
        have_prev = 1;
    endtask

    // Monitor: the output register presents a new bundle every cycle.
    initial begin
        bit [8:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({signals, ALUOp} !== e) begin
                    errors++;
                    $display("FAIL bundle: got %b/%b, required %b/%b",
                             signals, ALUOp, e[8:2], e[1:0]);
                end
                checks++;
                if ($isunknown({signals, ALUOp})) begin
                    errors++;
                    $display("FAIL known_bits: got %b/%b, required no X/Z", signals, ALUOp);
                end
                checks++;
                if ((signals[2] & signals[4]) || (signals[6] & signals[4]) || (ALUOp == 2'b11)) begin
                    errors++;
                    $display("FAIL invariants: got %b/%b, required no MemRead&MemWrite, RegWrite&MemWrite, ALUOp 11",
                             signals, ALUOp);
                end
            end
        end
    end

    initial begin
        bit [5:0] op;
        int wait_cyc;
        ref_tbl[6'b000000] = 9'b1000001_10;
        ref_tbl[6'b100011] = 9'b1101100_00;
        ref_tbl[6'b101011] = 9'b0110000_00;
        ref_tbl[6'b000100] = 9'b0000010_01;

        rst = 1'b1;
        ins = 6'b000000;

        step(1, 6'b000000);
        step(1, 6'b000000);
        step(0, 6'b000000);

        step(0, 6'b000000);
        step(0, 6'b100011);
        step(0, 6'b101011);
        step(0, 6'b000100);

        step(0, 6'b001000);
        step(0, 6'b000010);
        step(0, 6'b111111);

        for (int i = 0; i < 64; i++) begin
            op = 6'(i);
            step(0, op);
        end

        step(0, 6'b000100);
        step(1, 6'b100011);
        step(0, 6'b100011);

        step(0, 6'b000100);
        step(0, 6'b101011, 1);
        step(0, 6'b100011, 1);
        step(0, 6'b000000, 1);

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 7))
                0: op = 6'b000000;
                1: op = 6'b100011;
                2: op = 6'b101011;
                3: op = 6'b000100;
                default: op = 6'($urandom_range(0, 63));
            endcase
            step(($urandom_range(0, 19) == 0), op, ($urandom_range(0, 9) == 0));
        end

        wait_cyc = 0;
        while (exp_q.size() != 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
